uart_rx: RTL



---
 rtl/uart_rx.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: 2-FF sync, mid-bit sampling, sticky status flags.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_rx_clear,
  output logic [7:0] o_rx_data,
  output logic       o_rx_ready,
  output logic       o_overrun,
  output logic       o_framing_error,
  output logic       o_parity_error,
  output logic       o_rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    START_CHECK    = 3'd1,
    RECEIVE_DATA   = 3'd2,
    RECEIVE_PARITY = 3'd3,
    STOP_CHECK     = 3'd4,
    WAIT_IDLE      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             overrun_q, overrun_d;
  logic             ferr_q, ferr_d;
  logic             sample;
  logic             bit_done;
`ifdef UART_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  assign bit_done = (cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    ready_d   = ready_q;
    overrun_d = overrun_q;
    ferr_d    = ferr_q;
    sample    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif

    // Clear is applied first so a flag raised by a frame completing this cycle survives it.
    if (i_rx_clear) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
      ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d    = 1'b0;
`endif
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) state_d = START_CHECK;
      end
      START_CHECK: begin
        if (cnt_q == HALF_LAST) state_d = rx_s_q ? IDLE : RECEIVE_DATA;
      end
      RECEIVE_DATA: begin
        if (bit_done) begin
          sample  = 1'b1;
          shift_d = {rx_s_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = RECEIVE_PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP_CHECK;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      RECEIVE_PARITY: begin
        if (bit_done) begin
          par_d   = rx_s_q;
          state_d = STOP_CHECK;
        end
      end
`endif
      STOP_CHECK: begin
        if (bit_done) begin
          if (rx_s_q) begin
            state_d = IDLE;
            data_d  = shift_q;
            ready_d = 1'b1;
            if (ready_q && !i_rx_clear) overrun_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) perr_d = 1'b1;
`endif
          end else begin
            state_d = WAIT_IDLE;
            ferr_d  = 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        // A held-low break must not look like a fresh start bit.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) idx_d = 3'd0;

    if (state_d != state_q || sample || state_q == IDLE || state_q == WAIT_IDLE)
      cnt_d = '0;
    else
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= i_rx;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign o_parity_error = perr_q;
`else
  assign o_parity_error = 1'b0;
`endif

  assign o_rx_data       = data_q;
  assign o_rx_ready      = ready_q;
  assign o_overrun       = overrun_q;
  assign o_framing_error = ferr_q;
  assign o_rx_busy       = (state_q != IDLE);

endmodule
